wb_register_file: RTL
=====================

// Module: wb_register_file
// PURPOSE
//  Architectural register file fed by the write-back (mem-to-reg) 5:1 select stage.
//  Holds 2**ADDR_W registers of N bits with two combinational read ports and one clocked write port.
//  Register 0 reads as zero. A same-cycle write is bypassed to the read ports.
//  Provides a debug read port and a wrapping count of committed writes for bench and trace use.
// PARAMETERS
//  N       32  data width, matches the write-back select output width
//  ADDR_W  5   register address width; depth = 2**ADDR_W
//  CNT_W   16  width of the committed-write counter
// PORTS
//  clk        in   1       single clock; all state updates on rising edge
//  rst        in   1       asynchronous, active-low reset (asserts immediately, releases synchronously to clk)
//  rs1        in   ADDR_W  read address A
//  rs2        in   ADDR_W  read address B
//  rd         in   ADDR_W  write address
//  wr_en      in   1       write request (RegWrite)
//  wr_data    in   N       write data from the write-back select stage
//  rd_data1   out  N       read data A
//  rd_data2   out  N       read data B
//  dbg_addr   in   ADDR_W  debug read address
//  dbg_data   out  N       debug read data (no bypass; returns stored value)
//  wr_count   out  CNT_W   number of committed writes since reset
// BEHAVIOUR
//  - Reset (rst=0): all registers cleared to 0 and wr_count cleared to 0, both asynchronously.
//    Reads return 0 while reset is held. A write in the same edge as reset release is ignored.
//  - Commit: at the rising edge with rst=1, wr_en=1 and rd!=0, regs[rd] <= wr_data and wr_count <= wr_count+1.
//    wr_count wraps from 2**CNT_W-1 to 0.
//  - wr_en=1 with rd==0: no state change and no count increment. regs[0] stays 0 permanently.
//  - Read ports (0-cycle latency, combinational):
//      rdataX = 0                    if rsX==0
//             = wr_data              else if wr_en && rd==rsX   (write-through bypass)
//             = regs[rsX]            otherwise
//    Bypass applies to both ports independently. rs1==rs2==rd bypasses to both.
//  - dbg_data = regs[dbg_addr]: pre-write value, no bypass; dbg_addr==0 -> 0.
//  - X/unknown rd with wr_en=0 causes no write. Outputs never depend on stale wr_data when wr_en=0.
//  - No stall/handshake: every enabled edge commits. Upstream holds wr_en low on bubbles.
// STRUCTURE
//  - Shared package/header: XLEN=32, REG_ADDR_W=5, REG_COUNT=32, ZERO_REG=0.
//  - One sub-module: n_bit_reg_en (N-bit register, async active-low clear, load enable).
//    Instantiated 2**ADDR_W-1 times via generate; index 0 is a constant 0.
//    Write decode is one-hot of rd gated by wr_en.
//  - Read muxing and bypass stay in this module. wr_count is a local always block.
// TESTING
//  1. Reset: drive rst=0 mid-run after writing x5=0xDEADBEEF -> all reads 0 and wr_count=0 immediately, before the next edge.
//  2. Write/read: write x7=0x12345678, next cycle rs1=7 -> rd_data1=0x12345678 and wr_count=1.
//  3. x0: wr_en=1, rd=0, wr_data=0xFFFFFFFF -> rs1=0 reads 0, dbg_data(0)=0, wr_count unchanged.
//  4. Bypass: x3 holds 0x11; same cycle wr_en=1, rd=3, wr_data=0x22, rs1=rs2=3 -> both ports read 0x22, dbg_data=0x11; after the edge dbg_data=0x22.
//  5. wr_en=0 with rd=9, wr_data=0xAA -> x9 unchanged, no bypass, count unchanged.
//  6. Counter wrap: CNT_W=4, 17 writes to x1 -> wr_count=1. Also write all regs 1..31 with index*3 and read back through both ports.

Source files
------------

// File: rtl/wb_register_file_pkg.sv
// Shared widths and constants for the architectural register file.
// No logic; pure parameters.
// No flow control.
package wb_register_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/wb_register_file_n_bit_reg_en.sv
// N-bit storage register with load enable and asynchronous active-low clear.
// Latency: q reflects d one clock after en is sampled high.
// No backpressure: load is taken on every enabled edge.
//
// Ports:
//   clk  clock            rst  async active-low clear
//   en   load enable      d    data in      q    stored value
module n_bit_reg_en #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_register_file.sv
// Architectural register file: two bypassed read ports, one write port, debug port, write counter.
// Latency: reads combinational (0 cycles); writes commit at the next rising edge.
// No backpressure: every enabled edge with rd!=0 commits; upstream drops wr_en on bubbles.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   rs1/rs2 -> rd_data1/2    read ports, same-cycle write bypassed in
//   rd, wr_en, wr_data       write port
//   dbg_addr -> dbg_data     stored value only, no bypass
//   wr_count                 wrapping count of committed writes
module wb_register_file
    import wb_register_file_pkg::*;
#(
    parameter int N      = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wr_en,
    input  logic [N-1:0]      wr_data,
    output logic [N-1:0]      rd_data1,
    output logic [N-1:0]      rd_data2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [N-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic             commit;
    logic             byp1;
    logic             byp2;

    // A commit needs a real destination; writes to x0 are dropped entirely.
    assign commit = wr_en && (rd != ZERO_ADDR);

    // One-hot write decode; bit 0 never set so x0 has no storage to load.
    always_comb begin
        wr_sel = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr_sel[i] = wr_en && (rd == ADDR_W'(i));
        end
    end

    assign regs[0] = '0;

    generate
        for (genvar g = 1; g < DEPTH; g++) begin : g_reg
            n_bit_reg_en #(.N(N)) u_reg (
                .clk (clk),
                .rst (rst),
                .en  (wr_sel[g]),
                .d   (wr_data),
                .q   (regs[g])
            );
        end
    endgenerate

    // Bypass is suppressed while reset is held so reads stay zero during reset
    // even if the write-back stage is still presenting a write.
    assign byp1 = rst && wr_en && (rd == rs1);
    assign byp2 = rst && wr_en && (rd == rs2);

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rs1 != ZERO_ADDR) begin
            rd_data1 = byp1 ? wr_data : regs[rs1];
        end
        if (rs2 != ZERO_ADDR) begin
            rd_data2 = byp2 ? wr_data : regs[rs2];
        end
    end

    // Debug view is the stored state; regs[0] is tied to zero.
    assign dbg_data = regs[dbg_addr];

    // Wraps naturally at 2**CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
        end else if (commit) begin
            wr_count <= wr_count + CNT_W'(1);
        end
    end

endmodule
